// File: rtl/sram_stream_pkg.sv
// Shared definitions for the SRAM stream reader: FIFO sizing and FSM state type.
package sram_stream_pkg;

   // Elastic buffer between the SRAM read port and the output stream
   localparam int FIFO_DEPTH = 4;
   // Width of an occupancy count that can hold 0..FIFO_DEPTH
   localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/sram_stream_reader_fifo.sv
// stream_fifo: small synchronous FIFO with registered occupancy count.
// Push is unconditional when push_i is high; the producer guarantees space.
module stream_fifo #(
   parameter int  W     = 8,
   parameter int  DEPTH = 4,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [W-1:0]  data_i,
   input  logic          pop_i,
   output logic [W-1:0]  data_o,
   output logic          valid_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_pop;

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign valid_o = (count_q != '0);
   assign do_pop  = pop_i && valid_o;
   assign count_o = count_q;
   // Head is masked while empty so stale storage never shows on the output
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

   // Storage write
   // NOTE: storage is deliberately not reset; emptiness is tracked by count_q
   // and the output mask above, which keeps the array a plain RAM.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
   end

   // Pointer and occupancy bookkeeping
   // NOTE: all sequential state uses non-blocking assignment so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= inc_ptr(wr_ptr_q);
         if (do_pop) rd_ptr_q <= inc_ptr(rd_ptr_q);
         count_q <= count_q + CW'(push_i) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/sram_stream_reader.sv
// sram_stream_reader: reads len consecutive SRAM words starting at base_addr
// (address wraps) and streams them out with valid/ready and a last flag.
// Optional feature: define SRAM_RD_STALL_CNT_EN to count backpressure cycles
// on stall_cnt; otherwise stall_cnt is tied to zero.
module sram_stream_reader
   import sram_stream_pkg::*;
#(
   parameter int DW = 256,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic          re,
   output logic [AW-1:0] ra,
   input  logic [DW-1:0] rd,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_last,
   output logic [15:0]   stall_cnt
);

   localparam logic [AW:0] LEN_ONE = (AW + 1)'(1);

   state_e              state_q;
   logic [AW-1:0]       base_q;
   logic [AW:0]         len_q;
   logic [AW:0]         issued_q;
   logic [AW:0]         sent_q;
   logic                inflight_q;
   logic                done_q;
   logic [FIFO_CW-1:0]  fifo_count;
   logic                credit_ok;
   logic                hs;

   // Read issue uses only registered occupancy, so m_ready never reaches re
   assign credit_ok = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
   assign re        = (state_q == ST_RUN) && (issued_q < len_q) && credit_ok;
   assign ra        = base_q + issued_q[AW-1:0];
   assign hs        = m_valid && m_ready;
   assign m_last    = m_valid && (sent_q == len_q - LEN_ONE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;

   // Read data lands one cycle after re and is captured unconditionally
   stream_fifo #(
      .W     (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (inflight_q),
      .data_i  (rd),
      .pop_i   (hs),
      .data_o  (m_data),
      .valid_o (m_valid),
      .count_o (fifo_count)
   );

   // Burst control FSM with issue/delivery counters and the done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         sent_q     <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         inflight_q <= re;
         if (re) issued_q <= issued_q + LEN_ONE;
         if (hs) sent_q   <= sent_q + LEN_ONE;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  base_q   <= base_addr;
                  len_q    <= len;
                  issued_q <= '0;
                  sent_q   <= '0;
                  if (len == '0) done_q  <= 1'b1;
                  else           state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (re && (issued_q + LEN_ONE == len_q)) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // Popping the last word leaves the FIFO empty with nothing in flight
               if (hs && m_last) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef SRAM_RD_STALL_CNT_EN
   logic [15:0] stall_q;

   // Saturating count of cycles the stream is held off by the consumer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if ((state_q == ST_IDLE) && start) begin
         stall_q <= '0;
      end else if (m_valid && !m_ready && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader: scoreboard of expected words,
// addresses and done pulses fed by the stimulus, drained by a monitor.
module tb_sram_stream_reader;

   localparam int DW    = 256;
   localparam int AW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   len = '0;
   logic          busy, done, re, m_valid, m_last;
   logic [AW-1:0] ra;
   logic [DW-1:0] rd = '0;
   logic [DW-1:0] m_data;
   logic          m_ready = 1'b0;
   logic [15:0]   stall_cnt;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } word_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [DW-1:0] sram [DEPTH];
   word_t         exp_words[$];
   int            exp_ra[$];
   int            exp_done_cyc[$];
   int            re_cyc[$];
   int            first_valid_cyc = -1;
   int            words_seen = 0;
   int            stall_obs  = 0;
   bit            mon_en = 1'b0;
   int            ready_mode = 0;
   int            ready_base = 0;

   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   bit            want_done;
   word_t         mon_w;

   sram_stream_reader #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .re        (re),
      .ra        (ra),
      .rd        (rd),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: data for an address read with re appears the next cycle
   always @(posedge clk) if (re) rd <= sram[ra];

   // Consumer ready pattern: 0 always, 1 random, 2 toggling, 3 held low
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = 1'($urandom_range(0, 1));
         2:       m_ready = (((cyc - ready_base) % 2) == 0);
         default: m_ready = 1'b0;
      endcase
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares every address, word, hold and done pulse against the queues
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         want_done = (exp_done_cyc.size() > 0) && (exp_done_cyc[0] == cyc);
         if (want_done) void'(exp_done_cyc.pop_front());
         if (done || want_done) check("done", done, want_done);
         if (done) check("busy_in_done", busy, 0);
         if (re) begin
            re_cyc.push_back(cyc);
            if (exp_ra.size() == 0) check("re_unexpected", re, 0);
            else check("ra", ra, exp_ra.pop_front());
         end
         if (prev_stall) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_data);
            check("hold_last", m_last, prev_last);
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         if (m_valid && !m_ready) stall_obs++;
         if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (m_valid && m_ready) begin
            if (exp_words.size() == 0) begin
               check("word_unexpected", m_valid, 0);
            end else begin
               mon_w = exp_words.pop_front();
               check("data", m_data, mon_w.data);
               check("last", m_last, mon_w.last);
               if (mon_w.last) exp_done_cyc.push_back(cyc + 1);
            end
            words_seen++;
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic run_burst(input logic [AW-1:0] b, input int n, input int mode, output int start_c);
      word_t w;
      @(posedge clk); #1;
      ready_mode = mode;
      ready_base = cyc;
      base_addr  = b;
      len        = n[AW:0];
      start      = 1'b1;
      start_c    = cyc;
      for (int k = 0; k < n; k++) begin
         exp_ra.push_back((int'(b) + k) % DEPTH);
         w.data = sram[(int'(b) + k) % DEPTH];
         w.last = (k == n - 1);
         exp_words.push_back(w);
      end
      if (n == 0) exp_done_cyc.push_back(cyc + 1);
      re_cyc.delete();
      first_valid_cyc = -1;
      words_seen = 0;
      stall_obs  = 0;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", busy, (n != 0));
   endtask

   task automatic wait_done(input string tag, output int done_c);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!done && t < 3000);
      check({tag, "_done_seen"}, done, 1);
      done_c = cyc;
      check({tag, "_words_left"}, exp_words.size(), 0);
      check({tag, "_addr_left"}, exp_ra.size(), 0);
`ifdef SRAM_RD_STALL_CNT_EN
      check({tag, "_stall_cnt"}, stall_cnt, stall_obs);
`else
      check({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
      exp_words.delete();
      exp_ra.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_re"}, re, 0);
      check({tag, "_ra"}, ra, 0);
      check({tag, "_m_valid"}, m_valid, 0);
      check({tag, "_m_last"}, m_last, 0);
      check({tag, "_m_data"}, m_data, 0);
      check({tag, "_stall_cnt"}, stall_cnt, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int sc, dc, t;
      for (int i = 0; i < DEPTH; i++)
         for (int j = 0; j < DW / 32; j++)
            sram[i][j*32 +: 32] = $urandom();

      // Reset state
      #12;
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Basic burst with full-rate consumer: latency and back-to-back timing
      run_burst(8'h10, 4, 0, sc);
      wait_done("basic", dc);
      check("basic_re_count", re_cyc.size(), 4);
      check("basic_first_re", re_cyc[0], sc + 1);
      check("basic_last_re", re_cyc[3], sc + 4);
      check("basic_first_valid", first_valid_cyc, sc + 3);
      check("basic_done_cycle", dc, sc + 7);

      // Address wrap
      run_burst(8'hFE, 4, 0, sc);
      wait_done("wrap", dc);

      // Full-depth burst with alternating backpressure
      run_burst(8'($urandom()), 256, 2, sc);
      wait_done("full", dc);
      check("full_words", words_seen, 256);
`ifdef SRAM_RD_STALL_CNT_EN
      check("full_stall_256", stall_cnt, 256);
`else
      check("full_stall_zero", stall_cnt, 0);
`endif

      // Zero-length request
      run_burst(8'h33, 0, 0, sc);
      wait_done("zero", dc);
      check("zero_no_re", re_cyc.size(), 0);
      check("zero_done_cycle", dc, sc + 1);

      // Consumer held off: reads stop at FIFO capacity; a second start is ignored
      run_burst(8'h80, 8, 3, sc);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      base_addr = 8'h05;
      len       = 9'd3;
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("stall_re_count", re_cyc.size(), 4);
      check("stall_valid", m_valid, 1);
      @(posedge clk); #1;
      ready_mode = 0;
      wait_done("stall", dc);
      check("stall_words", words_seen, 8);

      // Random bursts with random backpressure
      for (int r = 0; r < 6; r++) begin
         run_burst(8'($urandom()), $urandom_range(1, 40), 1, sc);
         wait_done("rand", dc);
      end

      // Reset in the middle of a burst, then a fresh burst
      run_burst(8'h40, 16, 0, sc);
      t = 0;
      while (words_seen < 5 && t < 200) begin
         @(posedge clk);
         t++;
      end
      check("mid_words_reached", (words_seen >= 5), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      exp_words.delete();
      exp_ra.delete();
      exp_done_cyc.delete();
      repeat (2) @(negedge clk);
      check("mid_reset_hold_done", done, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_burst(8'($urandom()), 16, 1, sc);
      wait_done("after_reset", dc);
      check("after_reset_words", words_seen, 16);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_stream_reader.md
SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 SHALL have parameter DW, default 256, meaning SRAM word width in bits.
REQ-002 SHALL have parameter AW, default 8, meaning SRAM address width (depth 2^AW).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  AW  first SRAM address, sampled with start.
REQ-007 SHALL have port len  input  AW+1  word count 0..2^AW, sampled with start.
REQ-008 SHALL have port busy  output  1  burst in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-010 SHALL have port re  output  1  SRAM read enable.
REQ-011 SHALL have port ra  output  AW  SRAM read address.
REQ-012 SHALL have port rd  input  DW  SRAM read data, valid the cycle after re.
REQ-013 SHALL have ports m_valid output 1, m_ready input 1, m_data output DW, m_last output 1: output stream.
REQ-014 SHALL have port stall_cnt  output  16  backpressure cycle counter (see Configuration).

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start with len!=0; RUN->DRAIN when len reads issued; DRAIN->IDLE when FIFO empty and no read in flight.
REQ-016 SHALL, on start with len==0, stay IDLE, issue no reads, and pulse done the following cycle.
REQ-017 SHALL ignore start outside IDLE.
REQ-018 SHALL drive busy high in RUN and DRAIN only.
REQ-019 SHALL issue the k-th read (k=0..len-1) at ra = (base_addr + k) mod 2^AW; address wraps silently.
REQ-020 SHALL first assert re the cycle after start is accepted.
REQ-021 SHALL capture rd into an internal FIFO of depth FIFO_DEPTH=4 at the end of the cycle following each re cycle, unconditionally.
REQ-022 SHALL assert re only when issued<len and (fifo_count + inflight) < FIFO_DEPTH, using registered counts only (no m_ready-to-re combinational path).
REQ-023 SHALL present FIFO head on m_data with m_valid = FIFO non-empty; word transfers when m_valid && m_ready.
REQ-024 SHALL hold m_data/m_valid/m_last stable while m_valid && !m_ready.
REQ-025 SHALL assert m_last with the len-th word only.
REQ-026 SHALL sustain one word per cycle with m_ready held high; start at cycle T gives first m_valid at T+3.
REQ-027 SHALL pulse done the cycle after the last-word handshake, coincident with the return to IDLE; busy is low in the done cycle.
REQ-028 SHALL never overflow or underflow the FIFO under any m_ready pattern.

Reset
REQ-029 SHALL, while rst_n low, force IDLE, busy=0, done=0, re=0, ra=0, m_valid=0, m_last=0, m_data=0, stall_cnt=0, and empty the FIFO and all counters.
REQ-030 SHALL abandon a burst on reset mid-operation; in-flight SRAM data is discarded and no done is pulsed.

Configuration
REQ-031 SHALL, with macro SRAM_RD_STALL_CNT_EN defined, increment stall_cnt each cycle m_valid && !m_ready, saturating at 0xFFFF, clearing on accepted start.
REQ-032 SHALL, without SRAM_RD_STALL_CNT_EN, keep the stall_cnt port and tie it to 0 with no counter logic.

Structure
REQ-033 SHALL take FIFO_DEPTH and the state enum typedef from shared package sram_stream_pkg.
REQ-034 SHALL implement the FIFO as one sub-module, stream_fifo (parameterised width, depth).

Verification
REQ-035 SHALL cover: base_addr=0x10, len=4, m_ready=1 -> ra 0x10..0x13 on 4 consecutive cycles, 4 words back-to-back, m_last on 4th, done one cycle later.
REQ-036 SHALL cover: base_addr=0xFE, len=4 -> ra sequence 0xFE,0xFF,0x00,0x01.
REQ-037 SHALL cover: len=256, m_ready toggling 1/0 every cycle -> all 256 words in order, no loss, stall_cnt=256 with macro defined, 0 without.
REQ-038 SHALL cover: len=0 -> no re, done pulse cycle after start, busy stays 0.
REQ-039 SHALL cover: m_ready=0 for 10 cycles after start, len=8 -> re stops after 4 reads, m_data held, resumes on m_ready=1.
REQ-040 SHALL cover: rst_n low mid-burst (len=16, after 5 words) -> all outputs at reset values immediately, no done, next burst correct.
